// File: rtl/bcd_display_ctrl.sv
// Iterative binary-to-BCD (double-dabble) front end for the HEX seven-segment decoders.
// Optional leading-zero blanking is built when BCD_LEADING_BLANK_EN is defined.
module bcd_display_ctrl #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BIN_W-1:0]      in_value,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [4*DIGITS-1:0]   digits,
  output logic [DIGITS-1:0]     blank,
  output logic                  overflow,
  output logic                  done
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int SCR_W = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;
  logic                 load_s;
  logic                 step_s;
  logic                 latch_s;
  logic                 in_ready_r;
  logic [BIN_W-1:0]     bin_r;
  logic [SCR_W-1:0]     scratch_r;
  logic                 ovf_scr_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [SCR_W-1:0]     digits_r;
  logic                 overflow_r;
  logic                 done_r;
  logic [SCR_W-1:0]     corr_s;
  logic [SCR_W-1:0]     scr_shift_s;
  logic                 ovf_out_s;
  logic [BIN_W-1:0]     bin_nxt_s;

  // Per-digit add-3 correction; each nibble is independent, no carry between digits.
  function automatic logic [SCR_W-1:0] add3(input logic [SCR_W-1:0] s);
    logic [SCR_W-1:0] r;
    r = s;
    for (int k = 0; k < DIGITS; k++) begin
      if (s[4*k +: 4] >= 4'd5) begin
        r[4*k +: 4] = s[4*k +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  // Correct, then shift {scratch, binary} left; the scratch MSB falls out as overflow.
  always_comb begin
    corr_s                   = add3(scratch_r);
    {ovf_out_s, scr_shift_s} = {corr_s, bin_r[BIN_W-1]};
    bin_nxt_s                = bin_r << 1;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and datapath strobes.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    step_s      = 1'b0;
    latch_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          load_s      = 1'b1;
          state_nxt_s = SHIFT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        step_s = 1'b1;
        if (cnt_r == CNT_W'(BIN_W - 1)) begin
          state_nxt_s = LATCH;
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      LATCH: begin
        latch_s     = 1'b1;
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Conversion datapath and output bank; outputs only move on the LATCH cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready_r <= 1'b1;
      bin_r      <= {BIN_W{1'b0}};
      scratch_r  <= {SCR_W{1'b0}};
      ovf_scr_r  <= 1'b0;
      cnt_r      <= {CNT_W{1'b0}};
      digits_r   <= {SCR_W{1'b0}};
      overflow_r <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      in_ready_r <= (state_nxt_s == IDLE);
      done_r     <= latch_s;
      if (load_s) begin
        bin_r     <= in_value;
        scratch_r <= {SCR_W{1'b0}};
        ovf_scr_r <= 1'b0;
        cnt_r     <= {CNT_W{1'b0}};
      end else if (step_s) begin
        bin_r     <= bin_nxt_s;
        scratch_r <= scr_shift_s;
        ovf_scr_r <= ovf_scr_r | ovf_out_s;
        cnt_r     <= cnt_r + CNT_W'(1);
      end
      if (latch_s) begin
        digits_r   <= scratch_r;
        overflow_r <= ovf_scr_r;
      end
    end
  end

`ifdef BCD_LEADING_BLANK_EN
  localparam logic [DIGITS-1:0] BLANK_RST = ~(DIGITS'(1));

  logic [DIGITS-1:0] blank_r;

  // Blank every digit above the highest nonzero one; digit 0 always shows.
  function automatic logic [DIGITS-1:0] lead_blank(input logic [SCR_W-1:0] s);
    logic [DIGITS-1:0] b;
    logic              seen;
    b    = {DIGITS{1'b0}};
    seen = 1'b0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      if (s[4*k +: 4] != 4'd0) begin
        seen = 1'b1;
      end
      b[k] = ~seen;
    end
    return b;
  endfunction

  // Blank flags update together with the digits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blank_r <= BLANK_RST;
    end else if (latch_s) begin
      blank_r <= ovf_scr_r ? {DIGITS{1'b0}} : lead_blank(scratch_r);
    end
  end

  assign blank = blank_r;
`else
  assign blank = {DIGITS{1'b0}};
`endif

  assign in_ready = in_ready_r;
  assign digits   = digits_r;
  assign overflow = overflow_r;
  assign done     = done_r;

endmodule
